ctrl_unit_prog: RTL and testbench
=================================

Name: ctrl_unit_prog

Overview:
Programmable, registered instruction-decode control unit. It is the parametrised successor to the fixed-table control unit.
- Opcode-to-control-word mapping lives in a run-time writable table of DEPTH entries, not a hard-coded case list.
- Adds pipeline stall/flush, a two-word (immediate) instruction phase, a halt state with resume, and unknown-opcode detection.
- Sits between the instruction register and the datapath control bus.

Parameters:
OPC_W, 7, opcode width
SIG_W, 23, control word width
DEPTH, 16, decode table entries (power of 2, >=2)
NOP_SIG, 23'b01100111000001110100001, control word driven on reset, miss and flush
HLT_OPC, 7'b1100001, opcode that enters HALT
IMM_BIT, 22, control word bit marking an instruction followed by an immediate word

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
opcode  in  OPC_W  opcode of current instruction word
op_valid  in  1  opcode valid this cycle
stall  in  1  hold decode state
flush  in  1  squash in-flight decode
resume  in  1  leave HALT
cfg_we  in  1  table write strobe
cfg_idx  in  log2(DEPTH)  table entry index
cfg_en  in  1  valid bit written to entry
cfg_opcode  in  OPC_W  opcode written to entry
cfg_sig  in  SIG_W  control word written to entry
signals  out  SIG_W  registered control word
sig_valid  out  1  signals belongs to a newly decoded instruction
miss  out  1  one-cycle pulse: accepted opcode matched no valid entry
imm_phase  out  1  one-cycle pulse: current word consumed as immediate
halted  out  1  FSM in HALT

Behaviour:
- Reset (reset=0, async): every table entry is invalid; signals=NOP_SIG; sig_valid, miss, imm_phase and halted are 0; state=RUN.
- State machine has three states: RUN, IMM and HALT. Decode latency is 1 cycle, so outputs update on the edge after the input is accepted.
- Lookup is associative across valid entries whose opcode equals the input. If several entries match, the lowest index wins.
- Table write: on cfg_we, entry[cfg_idx] <= {cfg_en, cfg_opcode, cfg_sig} at the edge.
  - Writes are accepted in every state, including during stall.
  - A lookup in the same cycle as a write uses the pre-write contents.
- Priority per edge: flush > stall > normal operation.
- flush:
  - signals <= NOP_SIG; sig_valid, miss and imm_phase <= 0.
  - IMM -> RUN.
  - HALT stays HALT, and halted stays 1.
- stall (no flush):
  - state and signals hold.
  - sig_valid, miss and imm_phase <= 0.
  - op_valid is ignored.
- RUN with op_valid=1:
  - On a hit: signals <= entry sig and sig_valid <= 1.
    - If opcode == HLT_OPC, state -> HALT. The HLT word is still output with sig_valid=1.
    - Otherwise, if sig[IMM_BIT] = 1, state -> IMM.
  - On a miss: signals <= NOP_SIG, sig_valid <= 1, miss <= 1, state stays RUN.
- RUN with op_valid=0: signals hold; sig_valid and miss <= 0.
- IMM:
  - The next accepted op_valid word is an immediate and is not decoded. signals hold, sig_valid <= 0, imm_phase <= 1, state -> RUN.
  - Without op_valid, state stays IMM with all pulses 0.
- HALT:
  - halted=1; signals hold; sig_valid, miss and imm_phase <= 0; op_valid is ignored.
  - resume=1 -> RUN at the next edge, with halted <= 0 at the same edge.
  - resume is ignored outside HALT.
- A reset asserted in any state returns immediately to the reset values. The table is lost and must be reprogrammed.

Test Plan:
1. Reset, then program entry0 = {1, 7'b0000001, 23'b01110111000000001100011}. Drive opcode 0000001 with op_valid -> next cycle signals = 23'b01110111000000001100011, sig_valid=1, miss=0.
2. With the table empty, drive opcode 0010001 -> signals = NOP_SIG, sig_valid=1, miss=1 for exactly one cycle.
3. Program entry1 = IADD {1, 7'b0100000, 23'b10110111100000001100011}. Drive IADD, then immediate word 7'b0000001 -> cycle 1 sig_valid=1; cycle 2 imm_phase=1, sig_valid=0, signals unchanged (the immediate is not decoded as ADD).
4. Program HLT_OPC with 23'b00000011000001110000001 and issue it -> signals = that word, halted=1. Further ADD opcodes are ignored. Pulse resume -> halted=0, and the next ADD decodes.
5. Program entry3 and entry1 with the same opcode but different sigs -> the entry1 sig is output.
6. In IMM state:
   - Assert stall -> state holds, imm_phase=0.
   - Assert flush -> signals = NOP_SIG, the next word decodes normally.
   - Drop reset mid-IMM -> all outputs return to reset values and the table is cleared (a subsequent ADD misses).

Source files
------------

// File: rtl/ctrl_unit_prog_if.sv
// Instruction-decode bus between the instruction register side and the
// programmable control unit: opcode handshake, pipeline controls, decode
// table configuration port and the registered control-word outputs.
interface ctrl_unit_prog_if #(
    parameter int OPC_W = 7,
    parameter int SIG_W = 23,
    parameter int DEPTH = 16
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [OPC_W-1:0] opcode;
    logic             op_valid;
    logic             stall;
    logic             flush;
    logic             resume;

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic             cfg_en;
    logic [OPC_W-1:0] cfg_opcode;
    logic [SIG_W-1:0] cfg_sig;

    logic [SIG_W-1:0] signals;
    logic             sig_valid;
    logic             miss;
    logic             imm_phase;
    logic             halted;

    // Side that issues instructions and programs the table.
    modport master (
        output opcode, op_valid, stall, flush, resume,
        output cfg_we, cfg_idx, cfg_en, cfg_opcode, cfg_sig,
        input  signals, sig_valid, miss, imm_phase, halted
    );

    // The control unit itself.
    modport slave (
        input  opcode, op_valid, stall, flush, resume,
        input  cfg_we, cfg_idx, cfg_en, cfg_opcode, cfg_sig,
        output signals, sig_valid, miss, imm_phase, halted
    );
endinterface

// File: rtl/ctrl_unit_prog.sv
// Programmable registered control unit. Opcodes are decoded through a
// run-time writable associative table (lowest matching index wins) into a
// control word, with stall/flush, an immediate-word phase and a HALT state.
module ctrl_unit_prog #(
    parameter int                 OPC_W   = 7,
    parameter int                 SIG_W   = 23,
    parameter int                 DEPTH   = 16,
    parameter logic [SIG_W-1:0]   NOP_SIG = 23'b01100111000001110100001,
    parameter logic [OPC_W-1:0]   HLT_OPC = 7'b1100001,
    parameter int                 IMM_BIT = 22
) (
    input logic              clk,
    input logic              reset,
    ctrl_unit_prog_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN,
        ST_IMM,
        ST_HALT
    } state_t;

    state_t           state;

    logic             tbl_valid [DEPTH];
    logic [OPC_W-1:0] tbl_opc   [DEPTH];
    logic [SIG_W-1:0] tbl_sig   [DEPTH];

    logic             hit;
    logic [SIG_W-1:0] hit_sig;

    // Associative lookup over the pre-write table contents; scanning from the
    // top down lets the lowest matching index overwrite any higher match.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        hit     = 1'b0;
        hit_sig = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl_valid[i] && (tbl_opc[i] == bus.opcode)) begin
                hit     = 1'b1;
                hit_sig = tbl_sig[i];
            end
        end
    end

    // Entry valid bits: cleared by reset, rewritten on every table write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state always takes non-blocking assignments.
                tbl_valid[i] <= 1'b0;
            end
        end else if (bus.cfg_we) begin
            tbl_valid[bus.cfg_idx] <= bus.cfg_en;
        end
    end

    // Entry payload: opcode and control word of each table slot.
    // NOTE: the payload arrays are left out of reset; an invalid entry's contents are never used.
    always_ff @(posedge clk) begin
        if (bus.cfg_we) begin
            tbl_opc[bus.cfg_idx] <= bus.cfg_opcode;
            tbl_sig[bus.cfg_idx] <= bus.cfg_sig;
        end
    end

    // Decode FSM with registered outputs; priority flush > stall > normal.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_RUN;
            bus.signals   <= NOP_SIG;
            bus.sig_valid <= 1'b0;
            bus.miss      <= 1'b0;
            bus.imm_phase <= 1'b0;
            bus.halted    <= 1'b0;
        end else begin
            // Pulse outputs fall unless something below raises them.
            bus.sig_valid <= 1'b0;
            bus.miss      <= 1'b0;
            bus.imm_phase <= 1'b0;

            if (bus.flush) begin
                bus.signals <= NOP_SIG;
                if (state == ST_IMM) begin
                    state <= ST_RUN;
                end
            end else if (!bus.stall) begin
                case (state)
                    ST_RUN: begin
                        if (bus.op_valid) begin
                            bus.sig_valid <= 1'b1;
                            if (hit) begin
                                bus.signals <= hit_sig;
                                if (bus.opcode == HLT_OPC) begin
                                    state      <= ST_HALT;
                                    bus.halted <= 1'b1;
                                end else if (hit_sig[IMM_BIT]) begin
                                    state <= ST_IMM;
                                end
                            end else begin
                                bus.signals <= NOP_SIG;
                                bus.miss    <= 1'b1;
                            end
                        end
                    end
                    ST_IMM: begin
                        if (bus.op_valid) begin
                            bus.imm_phase <= 1'b1;
                            state         <= ST_RUN;
                        end
                    end
                    ST_HALT: begin
                        if (bus.resume) begin
                            state      <= ST_RUN;
                            bus.halted <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_RUN;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ctrl_unit_prog.sv
// Self-checking bench for ctrl_unit_prog: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// decode table and the run / immediate / halt behaviour.
module tb_ctrl_unit_prog;
    localparam int          OPC_W   = 7;
    localparam int          SIG_W   = 23;
    localparam int          DEPTH   = 16;
    localparam int          IDX_W   = $clog2(DEPTH);
    localparam logic [22:0] NOP_SIG = 23'b01100111000001110100001;
    localparam logic [6:0]  HLT_OPC = 7'b1100001;
    localparam int          IMM_BIT = 22;

    localparam logic [6:0]  ADD_OPC  = 7'b0000001;
    localparam logic [22:0] ADD_SIG  = 23'b01110111000000001100011;
    localparam logic [6:0]  IADD_OPC = 7'b0100000;
    localparam logic [22:0] IADD_SIG = 23'b10110111100000001100011;
    localparam logic [22:0] HLT_SIG  = 23'b00000011000001110000001;
    localparam logic [6:0]  DUP_OPC  = 7'b0000101;
    localparam logic [22:0] SIG_A    = 23'h0000AA;
    localparam logic [22:0] SIG_B    = 23'h000055;

    logic clk;
    logic reset;

    int checks;
    int failures;

    ctrl_unit_prog_if #(.OPC_W(OPC_W), .SIG_W(SIG_W), .DEPTH(DEPTH)) bus ();

    ctrl_unit_prog #(
        .OPC_W(OPC_W), .SIG_W(SIG_W), .DEPTH(DEPTH),
        .NOP_SIG(NOP_SIG), .HLT_OPC(HLT_OPC), .IMM_BIT(IMM_BIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: table as plain arrays, progress as two flags.
    logic             m_valid [DEPTH];
    logic [OPC_W-1:0] m_opc   [DEPTH];
    logic [SIG_W-1:0] m_sig   [DEPTH];
    bit               m_waiting_imm;
    bit               m_is_halted;
    logic [SIG_W-1:0] e_signals;
    bit               e_sig_valid;
    bit               e_miss;
    bit               e_imm_phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_waiting_imm = 0;
        m_is_halted   = 0;
        e_signals     = NOP_SIG;
        e_sig_valid   = 0;
        e_miss        = 0;
        e_imm_phase   = 0;
    endtask

    // Applies the inputs present at this edge to the model.
    task automatic model_step();
        bit               found;
        logic [SIG_W-1:0] found_sig;
        found     = 0;
        found_sig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && m_valid[i] && m_opc[i] == bus.opcode) begin
                found     = 1;
                found_sig = m_sig[i];
            end
        end
        e_sig_valid = 0;
        e_miss      = 0;
        e_imm_phase = 0;
        if (bus.flush) begin
            e_signals     = NOP_SIG;
            m_waiting_imm = 0;
        end else if (bus.stall) begin
            // nothing moves
        end else if (m_is_halted) begin
            if (bus.resume) m_is_halted = 0;
        end else if (m_waiting_imm) begin
            if (bus.op_valid) begin
                e_imm_phase   = 1;
                m_waiting_imm = 0;
            end
        end else if (bus.op_valid) begin
            e_sig_valid = 1;
            if (found) begin
                e_signals = found_sig;
                if (bus.opcode == HLT_OPC) m_is_halted = 1;
                else m_waiting_imm = found_sig[IMM_BIT];
            end else begin
                e_signals = NOP_SIG;
                e_miss    = 1;
            end
        end
        if (bus.cfg_we) begin
            m_valid[bus.cfg_idx] = bus.cfg_en;
            m_opc[bus.cfg_idx]   = bus.cfg_opcode;
            m_sig[bus.cfg_idx]   = bus.cfg_sig;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".signals"},   {9'b0, bus.signals}, {9'b0, e_signals});
        check({tag, ".sig_valid"}, {31'b0, bus.sig_valid}, {31'b0, e_sig_valid});
        check({tag, ".miss"},      {31'b0, bus.miss}, {31'b0, e_miss});
        check({tag, ".imm_phase"}, {31'b0, bus.imm_phase}, {31'b0, e_imm_phase});
        check({tag, ".halted"},    {31'b0, bus.halted}, {31'b0, m_is_halted});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    task automatic issue(input logic [6:0] op, input string tag);
        bus.opcode   = op;
        bus.op_valid = 1'b1;
        tick(tag);
        bus.op_valid = 1'b0;
    endtask

    task automatic cfg(input int idx, input logic en, input logic [6:0] op, input logic [22:0] sig);
        bus.op_valid   = 1'b0;
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = IDX_W'(idx);
        bus.cfg_en     = en;
        bus.cfg_opcode = op;
        bus.cfg_sig    = sig;
        tick("cfg");
        bus.cfg_we     = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [6:0] pick_opcode();
        case ($urandom_range(0, 5))
            0:       return ADD_OPC;
            1:       return IADD_OPC;
            2:       return HLT_OPC;
            3:       return DUP_OPC;
            4:       return 7'b0010001;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        bus.opcode = '0; bus.op_valid = 0; bus.stall = 0; bus.flush = 0; bus.resume = 0;
        bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_en = 0; bus.cfg_opcode = '0; bus.cfg_sig = '0;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all("reset");
        reset = 1'b1;

        // Empty table: any opcode misses for a single cycle.
        issue(7'b0010001, "t2_miss");
        check("t2_miss_pulse", {31'b0, bus.miss}, 32'd1);
        tick("t2_after");
        check("t2_miss_clear", {31'b0, bus.miss}, 32'd0);

        // Basic decode through entry0.
        cfg(0, 1'b1, ADD_OPC, ADD_SIG);
        issue(ADD_OPC, "t1_add");
        check("t1_signals", {9'b0, bus.signals}, {9'b0, ADD_SIG});

        // Immediate-carrying instruction followed by its immediate word.
        cfg(1, 1'b1, IADD_OPC, IADD_SIG);
        issue(IADD_OPC, "t3_iadd");
        issue(ADD_OPC, "t3_imm");
        check("t3_imm_phase", {31'b0, bus.imm_phase}, 32'd1);
        check("t3_signals_hold", {9'b0, bus.signals}, {9'b0, IADD_SIG});

        // Halt, ignored opcodes, resume, normal decode again.
        cfg(2, 1'b1, HLT_OPC, HLT_SIG);
        issue(HLT_OPC, "t4_hlt");
        check("t4_halted", {31'b0, bus.halted}, 32'd1);
        issue(ADD_OPC, "t4_ignored0");
        issue(ADD_OPC, "t4_ignored1");
        check("t4_hold_sig", {9'b0, bus.signals}, {9'b0, HLT_SIG});
        bus.resume = 1'b1;
        tick("t4_resume");
        bus.resume = 1'b0;
        check("t4_unhalted", {31'b0, bus.halted}, 32'd0);
        issue(ADD_OPC, "t4_add");
        check("t4_add_sig", {9'b0, bus.signals}, {9'b0, ADD_SIG});

        // Duplicate opcode: lowest index wins.
        cfg(3, 1'b1, DUP_OPC, SIG_A);
        cfg(1, 1'b1, DUP_OPC, SIG_B);
        issue(DUP_OPC, "t5_dup");
        check("t5_lowest", {9'b0, bus.signals}, {9'b0, SIG_B});

        // IMM state under stall, flush and reset.
        cfg(1, 1'b1, IADD_OPC, IADD_SIG);
        issue(IADD_OPC, "t6_iadd");
        bus.stall = 1'b1;
        issue(ADD_OPC, "t6_stall0");
        issue(ADD_OPC, "t6_stall1");
        check("t6_stall_imm", {31'b0, bus.imm_phase}, 32'd0);
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        tick("t6_flush");
        bus.flush = 1'b0;
        check("t6_flush_nop", {9'b0, bus.signals}, {9'b0, NOP_SIG});
        issue(ADD_OPC, "t6_after_flush");
        check("t6_decoded", {9'b0, bus.signals}, {9'b0, ADD_SIG});
        issue(IADD_OPC, "t6_iadd2");
        do_reset("t6_reset");
        issue(ADD_OPC, "t6_post_reset");
        check("t6_table_cleared", {31'b0, bus.miss}, 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bus.opcode     = pick_opcode();
            bus.op_valid   = ($urandom_range(0, 9) < 7);
            bus.stall      = ($urandom_range(0, 9) == 0);
            bus.flush      = ($urandom_range(0, 19) == 0);
            bus.resume     = ($urandom_range(0, 3) == 0);
            bus.cfg_we     = ($urandom_range(0, 6) == 0);
            bus.cfg_idx    = IDX_W'($urandom);
            bus.cfg_en     = ($urandom_range(0, 4) != 0);
            bus.cfg_opcode = pick_opcode();
            bus.cfg_sig    = SIG_W'($urandom);
            tick("rand");
            if (n % 700 == 699) begin
                bus.cfg_we = 1'b0;
                do_reset("rand_reset");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
